// File: rtl/rom_chip_pkg.sv
// Shared state encoding and operation codes for the PROM sequencers (rom_reader / rom_writer).
package rom_chip_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_PULSE   = 3'd2,
    ST_RECOVER = 3'd3,
    ST_CHECK   = 3'd4,
    ST_DONE    = 3'd5,
    ST_FAIL    = 3'd6
  } state_t;

  localparam logic [3:0] OP_IDLE    = 4'd0;
  localparam logic [3:0] OP_SETTLE  = 4'd1;
  localparam logic [3:0] OP_PULSE   = 4'd2;
  localparam logic [3:0] OP_RECOVER = 4'd3;
  localparam logic [3:0] OP_CHECK   = 4'd4;
  localparam logic [3:0] OP_DONE    = 4'd5;
  localparam logic [3:0] OP_FAIL    = 4'd15;

  function automatic logic [3:0] op_code(input state_t s);
    logic [3:0] op;
    case (s)
      ST_IDLE:    op = OP_IDLE;
      ST_SETTLE:  op = OP_SETTLE;
      ST_PULSE:   op = OP_PULSE;
      ST_RECOVER: op = OP_RECOVER;
      ST_CHECK:   op = OP_CHECK;
      ST_DONE:    op = OP_DONE;
      ST_FAIL:    op = OP_FAIL;
      default:    op = OP_IDLE;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/rom_delay_counter.sv
// Loadable down-counter with zero flag; saturates at zero. Times both pulses and settles.
module rom_delay_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             count_zero
);

  logic [WIDTH-1:0] count_r;

  // Down-count register with synchronous load.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_r <= '0;
    end else if (load) begin
      count_r <= load_value;
    end else if (count_r != '0) begin
      count_r <= count_r - WIDTH'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign count_zero = (count_r == '0);

endmodule

// File: rtl/rom_writer.sv
// Fuse-PROM programming sequencer: per-bit pulses, readback verify, bounded retries.
// Optional build macro ROM_WRITER_AUTO_INCREMENT_EN: address register advances on each DONE.
module rom_writer
  import rom_chip_pkg::*;
#(
  parameter int DATA_WIDTH    = 4,
  parameter int ADDRESS_WIDTH = 8,
  parameter int PULSE_CYCLES  = 50,
  parameter int SETTLE_CYCLES = 4,
  parameter int MAX_RETRIES   = 3
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic [ADDRESS_WIDTH-1:0] address_in,
  input  logic [DATA_WIDTH-1:0]    data_in,
  input  logic [DATA_WIDTH-1:0]    data_line_in,
  output logic [ADDRESS_WIDTH-1:0] address_line,
  output logic [DATA_WIDTH-1:0]    program_data,
  output logic                     program_pulse,
  output logic                     busy,
  output logic                     done,
  output logic                     error,
  output logic [3:0]               operation
);

  localparam int CNT_MAX = (PULSE_CYCLES > SETTLE_CYCLES) ? PULSE_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int IDX_W   = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int RTR_W   = $clog2(MAX_RETRIES + 1);

  localparam logic [CNT_W-1:0]      SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]      PULSE_LOAD  = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [IDX_W-1:0]      IDX_LAST    = IDX_W'(DATA_WIDTH - 1);
  localparam logic [IDX_W-1:0]      IDX_ONE     = IDX_W'(1);
  localparam logic [RTR_W-1:0]      RTR_MAX     = RTR_W'(MAX_RETRIES);
  localparam logic [RTR_W-1:0]      RTR_ONE     = RTR_W'(1);
  localparam logic [DATA_WIDTH-1:0] BIT0        = DATA_WIDTH'(1);

  state_t                  state_r, state_s;
  logic [DATA_WIDTH-1:0]   target_r, target_s;
  logic [IDX_W-1:0]        bit_idx_r, bit_idx_s;
  logic [RTR_W-1:0]        retries_r, retries_s;
  logic [DATA_WIDTH-1:0]   program_data_r, program_data_s;
  logic                    program_pulse_r, program_pulse_s;
  logic                    busy_r, busy_s;
  logic                    done_r, done_s;
  logic                    error_r, error_s;
  logic [3:0]              operation_r;
  logic [ADDRESS_WIDTH-1:0] address_line_r;
  logic                    accept_s;
  logic                    cnt_load_s;
  logic [CNT_W-1:0]        cnt_value_s;
  logic                    cnt_zero_s;
  logic                    overprog_s;

  rom_delay_counter #(.WIDTH(CNT_W)) u_delay (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (cnt_load_s),
    .load_value (cnt_value_s),
    .count_zero (cnt_zero_s)
  );

  // Blown fuses the target does not want cannot be undone, so they abort the word.
  assign overprog_s = |(data_line_in & ~target_r);

  // Next-state and next-output logic of the programming sequencer.
  always_comb begin
    state_s         = state_r;
    target_s        = target_r;
    bit_idx_s       = bit_idx_r;
    retries_s       = retries_r;
    program_data_s  = program_data_r;
    program_pulse_s = program_pulse_r;
    busy_s          = busy_r;
    done_s          = 1'b0;
    error_s         = error_r;
    accept_s        = 1'b0;
    cnt_load_s      = 1'b0;
    cnt_value_s     = SETTLE_LOAD;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          accept_s   = 1'b1;
          target_s   = data_in;
          bit_idx_s  = '0;
          retries_s  = '0;
          cnt_load_s = 1'b1;
          busy_s     = 1'b1;
          error_s    = 1'b0;
          state_s    = ST_SETTLE;
        end else begin
          busy_s = 1'b0;
        end
      end
      ST_SETTLE, ST_RECOVER: begin
        if (cnt_zero_s) begin
          state_s = ST_CHECK;
        end else begin
          state_s = state_r;
        end
      end
      ST_PULSE: begin
        if (cnt_zero_s) begin
          program_pulse_s = 1'b0;
          program_data_s  = '0;
          cnt_load_s      = 1'b1;
          state_s         = ST_RECOVER;
        end else begin
          state_s = ST_PULSE;
        end
      end
      ST_CHECK: begin
        if (overprog_s) begin
          error_s = 1'b1;
          state_s = ST_FAIL;
        end else if (target_r[bit_idx_r] && !data_line_in[bit_idx_r]) begin
          if (retries_r == RTR_MAX) begin
            error_s = 1'b1;
            state_s = ST_FAIL;
          end else begin
            retries_s       = retries_r + RTR_ONE;
            program_data_s  = BIT0 << bit_idx_r;
            program_pulse_s = 1'b1;
            cnt_load_s      = 1'b1;
            cnt_value_s     = PULSE_LOAD;
            state_s         = ST_PULSE;
          end
        end else if (bit_idx_r == IDX_LAST) begin
          done_s  = 1'b1;
          state_s = ST_DONE;
        end else begin
          bit_idx_s = bit_idx_r + IDX_ONE;
          retries_s = '0;
        end
      end
      ST_DONE, ST_FAIL: begin
        busy_s  = 1'b0;
        state_s = ST_IDLE;
      end
      default: begin
        program_pulse_s = 1'b0;
        program_data_s  = '0;
        busy_s          = 1'b0;
        state_s         = ST_IDLE;
      end
    endcase
  end

  // State and registered-output update.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r         <= ST_IDLE;
      target_r        <= '0;
      bit_idx_r       <= '0;
      retries_r       <= '0;
      program_data_r  <= '0;
      program_pulse_r <= 1'b0;
      busy_r          <= 1'b0;
      done_r          <= 1'b0;
      error_r         <= 1'b0;
      operation_r     <= OP_IDLE;
    end else begin
      state_r         <= state_s;
      target_r        <= target_s;
      bit_idx_r       <= bit_idx_s;
      retries_r       <= retries_s;
      program_data_r  <= program_data_s;
      program_pulse_r <= program_pulse_s;
      busy_r          <= busy_s;
      done_r          <= done_s;
      error_r         <= error_s;
      operation_r     <= op_code(state_s);
    end
  end

`ifdef ROM_WRITER_AUTO_INCREMENT_EN
  logic [ADDRESS_WIDTH-1:0] next_addr_r;
  logic                     addr_valid_r;

  // Address register: seeded by the first start after reset, then advanced per finished word.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      address_line_r <= '0;
      next_addr_r    <= '0;
      addr_valid_r   <= 1'b0;
    end else if (accept_s) begin
      if (addr_valid_r) begin
        address_line_r <= next_addr_r;
      end else begin
        address_line_r <= address_in;
        next_addr_r    <= address_in;
      end
      addr_valid_r <= 1'b1;
    end else if (state_r == ST_DONE) begin
      next_addr_r <= next_addr_r + ADDRESS_WIDTH'(1);
    end else begin
      next_addr_r <= next_addr_r;
    end
  end
`else
  // Address register: loaded on every accepted start, held otherwise.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      address_line_r <= '0;
    end else if (accept_s) begin
      address_line_r <= address_in;
    end else begin
      address_line_r <= address_line_r;
    end
  end
`endif

  assign address_line  = address_line_r;
  assign program_data  = program_data_r;
  assign program_pulse = program_pulse_r;
  assign busy          = busy_r;
  assign done          = done_r;
  assign error         = error_r;
  assign operation     = operation_r;

endmodule

// File: tb/tb_rom_writer.sv
// Directed self-checking bench for rom_writer with a behavioural fuse-PROM model.
module tb_rom_writer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] address_in = 8'h00;
  logic [3:0] data_in = 4'h0;
  logic [3:0] data_line_in;
  logic [7:0] address_line;
  logic [3:0] program_data;
  logic       program_pulse;
  logic       busy;
  logic       done;
  logic       error;
  logic [3:0] operation;

  int total = 0;
  int bad = 0;

  rom_writer dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .address_in    (address_in),
    .data_in       (data_in),
    .data_line_in  (data_line_in),
    .address_line  (address_line),
    .program_data  (program_data),
    .program_pulse (program_pulse),
    .busy          (busy),
    .done          (done),
    .error         (error),
    .operation     (operation)
  );

  always #5 clk = ~clk;

  // Chip model: fuses blow while the pulse is applied, except stuck-at-0 bits.
  logic [3:0] mem [256] = '{default: 4'h0};
  logic [3:0] stuck = 4'h0;
  logic       pre_en = 1'b0;
  logic [7:0] pre_addr = 8'h00;
  logic [3:0] pre_val = 4'h0;
  assign data_line_in = mem[address_line];

  always @(posedge clk) begin
    if (pre_en) mem[pre_addr] <= pre_val;
    else if (program_pulse) mem[address_line] <= mem[address_line] | (program_data & ~stuck);
  end

  // Pulse monitor: count pulses, log their data, track high-time extremes, note done.
  logic       mon_clr = 1'b0;
  int         pulse_cnt = 0;
  int         cur_len = 0;
  int         len_min = 1000;
  int         len_max = 0;
  logic       prev_pulse = 1'b0;
  logic       done_seen = 1'b0;
  logic [3:0] pdata_log [8];

  always @(posedge clk) begin
    if (mon_clr) begin
      pulse_cnt <= 0; cur_len <= 0; len_min <= 1000; len_max <= 0;
      done_seen <= 1'b0; prev_pulse <= 1'b0;
    end else begin
      if (program_pulse && !prev_pulse) begin
        pdata_log[pulse_cnt[2:0]] <= program_data;
        pulse_cnt <= pulse_cnt + 1;
      end
      if (program_pulse) cur_len <= cur_len + 1;
      if (!program_pulse && prev_pulse) begin
        if (cur_len < len_min) len_min <= cur_len;
        if (cur_len > len_max) len_max <= cur_len;
        cur_len <= 0;
      end
      if (done) done_seen <= 1'b1;
      prev_pulse <= program_pulse;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    @(negedge clk); mon_clr = 1'b1;
    @(negedge clk); mon_clr = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); reset_n = 1'b0; start = 1'b0; mon_clr = 1'b1;
    @(negedge clk);
    @(negedge clk); reset_n = 1'b1; mon_clr = 1'b0;
  endtask

  task automatic preload(input logic [7:0] a, input logic [3:0] v);
    @(negedge clk); pre_en = 1'b1; pre_addr = a; pre_val = v;
    @(negedge clk); pre_en = 1'b0;
  endtask

  // Returns just after the edge that samples start.
  task automatic do_start(input logic [7:0] a, input logic [3:0] d);
    @(negedge clk); start = 1'b1; address_in = a; data_in = d;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_idle(input int max_cycles, input string tag);
    int n;
    n = 0;
    while (busy && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    check(tag, {31'd0, busy}, 32'd0);
  endtask

  logic [3:0] op_exp [9];

  initial begin
    op_exp = '{4'd1, 4'd1, 4'd1, 4'd1, 4'd4, 4'd4, 4'd4, 4'd4, 4'd5};

    // Reset state
    do_reset();
    check("rst_pulse", {31'd0, program_pulse}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_error", {31'd0, error}, 32'd0);
    check("rst_op", {28'd0, operation}, 32'd0);
    check("rst_addr", {24'd0, address_line}, 32'd0);
    check("rst_pdata", {28'd0, program_data}, 32'd0);

    // 1: blank chip, 0x05 <- B
    do_start(8'h05, 4'hB);
    check("t1_busy", {31'd0, busy}, 32'd1);
    check("t1_op_settle", {28'd0, operation}, 32'd1);
    wait_idle(1000, "t1_timeout");
    check("t1_pulses", pulse_cnt, 32'd3);
    check("t1_pd0", {28'd0, pdata_log[0]}, 32'h1);
    check("t1_pd1", {28'd0, pdata_log[1]}, 32'h2);
    check("t1_pd2", {28'd0, pdata_log[2]}, 32'h8);
    check("t1_len_min", len_min, 32'd50);
    check("t1_len_max", len_max, 32'd50);
    check("t1_done", {31'd0, done_seen}, 32'd1);
    check("t1_error", {31'd0, error}, 32'd0);
    check("t1_addr", {24'd0, address_line}, 32'h05);
    check("t1_chip", {28'd0, mem[8'h05]}, 32'hB);

    // 2: already programmed word, exact latency and operation trace
    do_reset();
    preload(8'h22, 4'hB);
    do_start(8'h22, 4'hB);
    for (int k = 0; k < 9; k++) begin
      check($sformatf("t2_op%0d", k), {28'd0, operation}, {28'd0, op_exp[k]});
      check($sformatf("t2_done%0d", k), {31'd0, done}, (k == 8) ? 32'd1 : 32'd0);
      if (k < 8) @(negedge clk);
    end
    @(negedge clk);
    check("t2_done_drop", {31'd0, done}, 32'd0);
    check("t2_busy_drop", {31'd0, busy}, 32'd0);
    check("t2_op_idle", {28'd0, operation}, 32'd0);
    check("t2_pulses", pulse_cnt, 32'd0);

    // 3: overprogrammed chip -> FAIL at first CHECK
    do_reset();
    preload(8'h33, 4'h4);
    do_start(8'h33, 4'h3);
    for (int k = 0; k < 20 && operation != 4'd15; k++) @(negedge clk);
    check("t3_op_fail", {28'd0, operation}, 32'd15);
    check("t3_error", {31'd0, error}, 32'd1);
    check("t3_pulses", pulse_cnt, 32'd0);
    @(negedge clk);
    check("t3_busy_drop", {31'd0, busy}, 32'd0);
    check("t3_error_sticky", {31'd0, error}, 32'd1);
    check("t3_op_idle", {28'd0, operation}, 32'd0);
    clear_mon();
    // error clears on the next accepted start; chip already matches 4'h4
    do_start(8'h33, 4'h4);
    check("t3_error_clear", {31'd0, error}, 32'd0);
    wait_idle(100, "t3_timeout");
    check("t3_redo_done", {31'd0, done_seen}, 32'd1);
    check("t3_redo_error", {31'd0, error}, 32'd0);

    // 4: bit2 stuck at 0 -> MAX_RETRIES pulses then error
    do_reset();
    stuck = 4'h4;
    do_start(8'h44, 4'h4);
    wait_idle(1000, "t4_timeout");
    check("t4_pulses", pulse_cnt, 32'd3);
    check("t4_pd0", {28'd0, pdata_log[0]}, 32'h4);
    check("t4_pd1", {28'd0, pdata_log[1]}, 32'h4);
    check("t4_pd2", {28'd0, pdata_log[2]}, 32'h4);
    check("t4_len_min", len_min, 32'd50);
    check("t4_len_max", len_max, 32'd50);
    check("t4_error", {31'd0, error}, 32'd1);
    check("t4_done", {31'd0, done_seen}, 32'd0);
    stuck = 4'h0;

    // 5: start while busy ignored; reset in the middle of a pulse
    do_reset();
    do_start(8'h55, 4'h1);
    start = 1'b1; address_in = 8'h66; data_in = 4'h0;
    @(negedge clk); start = 1'b0;
    check("t5_addr_kept", {24'd0, address_line}, 32'h55);
    check("t5_busy", {31'd0, busy}, 32'd1);
    for (int k = 0; k < 20 && !program_pulse; k++) @(negedge clk);
    check("t5_pulse_on", {31'd0, program_pulse}, 32'd1);
    check("t5_pdata_on", {28'd0, program_data}, 32'h1);
    repeat (9) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check("t5_rst_pulse", {31'd0, program_pulse}, 32'd0);
    check("t5_rst_busy", {31'd0, busy}, 32'd0);
    check("t5_rst_pdata", {28'd0, program_data}, 32'd0);
    check("t5_rst_op", {28'd0, operation}, 32'd0);
    reset_n = 1'b1;

    // 6: address source for the second start
    do_reset();
    do_start(8'hFF, 4'h1);
    wait_idle(200, "t6_timeout1");
    check("t6_done", {31'd0, done_seen}, 32'd1);
    check("t6_error", {31'd0, error}, 32'd0);
    do_start(8'h10, 4'h1);
`ifdef ROM_WRITER_AUTO_INCREMENT_EN
    check("t6_addr_next", {24'd0, address_line}, 32'h00);
`else
    check("t6_addr_next", {24'd0, address_line}, 32'h10);
`endif
    wait_idle(200, "t6_timeout2");
    check("t6_error2", {31'd0, error}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
